// File: rtl/verify_cmov_ctrl.sv
// verify_cmov_ctrl
//   Sequencer for the constant-time ciphertext compare and key cmov at the end
//   of Saber decapsulation. It streams ciphertext A and re-encrypted ciphertext
//   B out of the shared 64-bit memory and ORs A^B over every word. It then
//   copies KEY_WORDS words to DST_BASE, from the key bank on a match or from
//   the z bank on a mismatch. The cycle count never depends on the data.
//
//   Optional feature: define VERIFY_FLAG_OUT_EN to expose verify_flag.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   start            one-cycle request, sampled only in IDLE
//   busy             high from the cycle after acceptance through DONE
//   rd_base_sel      bank select during COPY (1 = key, 0 = z), 0 otherwise
//   read_address     memory read address; read_data returns one cycle later
//   read_data        registered memory read data
//   write_address    memory write address
//   write_data       memory write data
//   write_en         memory write strobe
//   done             one-cycle completion pulse
//   verify_flag      (VERIFY_FLAG_OUT_EN only) compare result of the last run
module verify_cmov_ctrl #(
    parameter int unsigned CT_WORDS  = 136,
    parameter logic [8:0]  CT_BASE_A = 9'd0,
    parameter logic [8:0]  CT_BASE_B = 9'd136,
    parameter int unsigned KEY_WORDS = 4,
    parameter logic [8:0]  KEY_BASE  = 9'd0,
    parameter logic [8:0]  DST_BASE  = 9'd272
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        rd_base_sel,
    output logic [8:0]  read_address,
    input  logic [63:0] read_data,
    output logic [8:0]  write_address,
    output logic [63:0] write_data,
    output logic        write_en,
    output logic        done
`ifdef VERIFY_FLAG_OUT_EN
    ,
    output logic        verify_flag
`endif
);

    localparam logic [7:0] CT_LAST = 8'(CT_WORDS - 1);
    localparam logic [3:0] KW      = 4'(KEY_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_DRAIN,
        S_COPY,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  i;           // ciphertext word index
    logic        phase;       // 0: A address, 1: B address
    logic [3:0]  j;           // copy index, 0..KEY_WORDS
    logic [63:0] a_lat;       // A word waiting for its B partner
    logic [63:0] diff_acc;
    logic        verify_true;
    logic [63:0] diff_fin;

    // OR-in of the B word that is on read_data this cycle
    assign diff_fin = diff_acc | (a_lat ^ read_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        read_address  = 9'd0;
        write_address = 9'd0;
        write_data    = 64'd0;
        write_en      = 1'b0;
        rd_base_sel   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CMP;
            end
            S_CMP: begin
                read_address = phase ? (CT_BASE_B + 9'(i)) : (CT_BASE_A + 9'(i));
                if (phase && (i == CT_LAST)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                state_nxt = S_COPY;
            end
            S_COPY: begin
                rd_base_sel = verify_true;
                if (j < KW) read_address = KEY_BASE + 9'(j);
                // Word j-1 arrives now; forward it straight to the write port.
                if (j != 4'd0) begin
                    write_en      = 1'b1;
                    write_address = DST_BASE + 9'(j) - 9'd1;
                    write_data    = read_data;
                end
                if (j == KW) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i           <= 8'd0;
            phase       <= 1'b0;
            j           <= 4'd0;
            a_lat       <= 64'd0;
            diff_acc    <= 64'd0;
            verify_true <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i           <= 8'd0;
                        phase       <= 1'b0;
                        j           <= 4'd0;
                        diff_acc    <= 64'd0;
                        verify_true <= 1'b0;
                    end
                end
                S_CMP: begin
                    phase <= ~phase;
                    if (phase) begin
                        // A[i] is on read_data while B[i] is being addressed
                        a_lat <= read_data;
                        i     <= i + 8'd1;
                    end else if (i != 8'd0) begin
                        // B[i-1] is on read_data
                        diff_acc <= diff_fin;
                    end
                end
                S_DRAIN: begin
                    diff_acc    <= diff_fin;
                    verify_true <= (diff_fin == 64'd0);
                end
                S_COPY: begin
                    j <= j + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef VERIFY_FLAG_OUT_EN
    assign verify_flag = verify_true;
`endif

endmodule

// File: tb/tb_verify_cmov_ctrl.sv
// Testbench for verify_cmov_ctrl with default parameters. A two-bank memory
// model feeds the DUT. A run model derives every output from the cycle offset
// since the accepted start, and a negedge process compares all outputs on
// every cycle. Directed scenarios add literal expectations for latency, write
// count, write addresses and data.
module tb_verify_cmov_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, rd_base_sel, write_en, done;
    logic [8:0]  read_address, write_address;
    logic [63:0] read_data, write_data;
`ifdef VERIFY_FLAG_OUT_EN
    logic        verify_flag;
`endif

    verify_cmov_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .rd_base_sel(rd_base_sel), .read_address(read_address),
        .read_data(read_data), .write_address(write_address),
        .write_data(write_data), .write_en(write_en), .done(done)
`ifdef VERIFY_FLAG_OUT_EN
        , .verify_flag(verify_flag)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] data_bank [512];
    logic [63:0] key_bank  [512];

    always @(posedge clk)
        read_data <= rd_base_sel ? key_bank[read_address] : data_bank[read_address];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- run model ----------------
    int cyc = 0;      // index of the current clock period
    int run_t = -1;   // period in which the current/last run was accepted
    bit run_match = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit active();
        return (run_t >= 0) && ((cyc - run_t) <= 279);
    endfunction

    function automatic bit bank_match();
        bit m = 1'b1;
        for (int k = 0; k < 136; k++)
            if (data_bank[k] != data_bank[136 + k]) m = 1'b0;
        return m;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) run_t <= -1;
        else if (start && !active()) begin
            run_t     <= cyc;
            run_match <= bank_match();
        end
    end

    // ---------------- compare + logging ----------------
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_cnt = 0;
    logic [8:0]  wr_a [$];
    logic [63:0] wr_d [$];

    always @(negedge clk) begin
        int off;
        logic        e_busy, e_done, e_we, e_sel, e_vf;
        logic [8:0]  e_ra, e_wa;
        logic [63:0] e_wd;
        off = (run_t >= 0) ? (cyc - run_t) : 100000;
        e_busy = 0; e_done = 0; e_we = 0; e_sel = 0; e_vf = 0;
        e_ra = 0; e_wa = 0; e_wd = 0;
        if (rst) begin
            e_busy = (off >= 1 && off <= 279);
            e_done = (off == 279);
            if (off >= 1 && off <= 272)
                e_ra = (((off - 1) % 2) == 1) ? 9'(136 + (off - 1) / 2) : 9'((off - 1) / 2);
            if (off >= 274 && off <= 277) e_ra = 9'(off - 274);
            if (off >= 274 && off <= 278) e_sel = run_match;
            if (off >= 275 && off <= 278) begin
                e_we = 1;
                e_wa = 9'(272 + off - 275);
                e_wd = run_match ? key_bank[off - 275] : data_bank[off - 275];
            end
            e_vf = (off >= 274 && off < 100000) ? run_match : 1'b0;
        end
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("read_address", 64'(read_address), 64'(e_ra));
        chk("rd_base_sel", 64'(rd_base_sel), 64'(e_sel));
        chk("write_en", 64'(write_en), 64'(e_we));
        chk("write_address", 64'(write_address), 64'(e_wa));
        chk("write_data", write_data, e_wd);
`ifdef VERIFY_FLAG_OUT_EN
        chk("verify_flag", 64'(verify_flag), 64'(e_vf));
`endif
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (write_en) begin
            wr_cnt++;
            wr_a.push_back(write_address);
            wr_d.push_back(write_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int t);
        @(posedge clk);
        #1;
        start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int t0);
        while (done_cnt == n0 && cyc < t0 + 400) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt == n0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // literal checks of one run's latency and written words
    task automatic chk_run(input string tag, input int t, input int w0, input bit key);
        chk({tag, "_latency"}, 64'(done_cyc - t), 64'd279);
        chk({tag, "_wr_count"}, 64'(wr_cnt - w0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (w0 + k < wr_cnt) begin
                chk({tag, "_wr_addr"}, 64'(wr_a[w0 + k]), 64'(272 + k));
                chk({tag, "_wr_data"}, wr_d[w0 + k],
                    key ? (64'hC0DE_0000_0000_0000 | 64'(k)) : (64'h5A5A_0000_0000_0000 | 64'(k)));
            end
        end
    endtask

    initial begin
        int t, t2, n0, w0;
        for (int k = 0; k < 512; k++) begin
            data_bank[k] = 64'd0;
            key_bank[k]  = 64'hC0DE_0000_0000_0000 | 64'(k);
        end
        for (int k = 0; k < 136; k++) begin
            data_bank[k]       = 64'h5A5A_0000_0000_0000 | 64'(k);
            data_bank[136 + k] = 64'h5A5A_0000_0000_0000 | 64'(k);
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: equal ciphertexts
        n0 = done_cnt; w0 = wr_cnt;
        pulse_start(t);
        wait_done(n0, t);
        chk_run("match", t, w0, 1'b1);

        // 2: mismatch only in bit 63 of word 135
        data_bank[271][63] = ~data_bank[271][63];
        repeat (2) @(posedge clk);
        n0 = done_cnt; w0 = wr_cnt;
        pulse_start(t);
        wait_done(n0, t);
        chk_run("mismatch", t, w0, 1'b0);
        data_bank[271][63] = ~data_bank[271][63];

        // 3: extra start pulses at T+10 and in DONE are ignored
        repeat (2) @(posedge clk);
        n0 = done_cnt; w0 = wr_cnt;
        pulse_start(t);
        wait_cyc(t + 10);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_cyc(t + 279);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_cyc(t + 300);
        chk("ignore_done_count", 64'(done_cnt - n0), 64'd1);
        chk_run("ignore", t, w0, 1'b1);

        // 4: reset in the middle of COPY
        n0 = done_cnt; w0 = wr_cnt;
        pulse_start(t);
        wait_cyc(t + 275);
        rst = 1'b0;
        #2;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_write_en", 64'(write_en), 64'd0);
        chk("midrst_rd_base_sel", 64'(rd_base_sel), 64'd0);
        chk("midrst_read_address", 64'(read_address), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_cyc(t + 320);
        chk("midrst_no_done", 64'(done_cnt - n0), 64'd0);
        chk("midrst_no_wr", 64'(wr_cnt - w0), 64'd0);
        n0 = done_cnt; w0 = wr_cnt;
        pulse_start(t);
        wait_done(n0, t);
        chk_run("after_rst", t, w0, 1'b1);

        // 5: back-to-back, match then mismatch
        repeat (2) @(posedge clk);
        n0 = done_cnt; w0 = wr_cnt;
        pulse_start(t);
`ifdef VERIFY_FLAG_OUT_EN
        wait_cyc(t + 273);
        chk("vflag_before_drain", 64'(verify_flag), 64'd0);
        wait_cyc(t + 274);
        chk("vflag_match", 64'(verify_flag), 64'd1);
`endif
        wait_done(n0, t);
        chk_run("b2b_first", t, w0, 1'b1);
        wait_cyc(t + 280);
        data_bank[271][63] = ~data_bank[271][63];
        start = 1'b1;
        t2 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_start_gap", 64'(t2 - t), 64'd280);
        chk("b2b_busy", 64'(busy), 64'd1);
`ifdef VERIFY_FLAG_OUT_EN
        chk("vflag_cleared", 64'(verify_flag), 64'd0);
`endif
        n0 = done_cnt; w0 = wr_cnt;
        wait_cyc(t2 + 276);
        chk("b2b_sel_z", 64'(rd_base_sel), 64'd0);
        wait_done(n0, t2);
        chk_run("b2b_second", t2, w0, 1'b0);
        data_bank[271][63] = ~data_bank[271][63];

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
